cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, per-source result queue depth (power of two, >=2).
REQ-002 Parameter ID_W, default 5, ROB entry id width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rdy  input  1  global enable; low freezes all state and outputs.
REQ-006 flush  input  1  mispredict flush from commit logic (wrong_commit).
REQ-007 alu_valid  input  1  ALU result offered.
REQ-008 alu_res  input  32  ALU result value.
REQ-009 alu_rob_id  input  ID_W  destination ROB entry.
REQ-010 alu_jump_choice  input  1  resolved branch direction.
REQ-011 alu_pc  input  32  resolved branch target.
REQ-012 alu_ready  output  1  ALU queue can accept.
REQ-013 lsb_valid  input  1  LSB result offered.
REQ-014 lsb_res  input  32  load result value.
REQ-015 lsb_rob_id  input  ID_W  destination ROB entry.
REQ-016 lsb_ready  output  1  LSB queue can accept.
REQ-017 cdb_valid  output  1  one broadcast this cycle, registered.
REQ-018 cdb_rob_id / cdb_res / cdb_jump_choice / cdb_pc  output  ID_W/32/1/32  broadcast payload, registered.
REQ-019 cdb_src  output  1  winning source, 0=ALU, 1=LSB.

Function
REQ-020 The block SHALL keep one DEPTH-entry FIFO per source; LSB entries store jump_choice=0, pc=0.
REQ-021 x_ready SHALL equal (count_x < DEPTH) from registered state only, independent of same-cycle pop.
REQ-022 A push SHALL occur at an edge where rdy && !flush && x_valid && x_ready; x_valid while !x_ready SHALL be dropped (protocol violation, assertion).
REQ-023 At each edge with rdy && !flush, if any queue was non-empty before the edge, exactly one head SHALL pop and load the cdb_* registers with cdb_valid=1; otherwise cdb_valid<=0.
REQ-024 Both non-empty: grant SHALL go to the source not granted last (round-robin); last_grant updates only on a grant.
REQ-025 An entry pushed at edge k SHALL NOT be granted before edge k+1 (no bypass); minimum latency: cdb_valid high in the cycle after edge k+1.
REQ-026 Simultaneous push and pop on one queue SHALL be legal when not full; count unchanged.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; order within a source SHALL be preserved.
REQ-028 flush at an edge (rdy high) SHALL empty both queues, cdb_valid<=0, last_grant<=LSB, ignore same-edge inputs; flush has priority over push and pop.
REQ-029 rdy low SHALL hold queues, pointers, last_grant and all outputs unchanged, flush included.
REQ-030 Throughput SHALL be one broadcast per cycle sustained while any queue is non-empty.

Reset
REQ-031 rst high SHALL asynchronously clear queues, pointers, counts, set last_grant=LSB (ALU wins first tie), and drive cdb_valid=0, cdb_rob_id=0, cdb_res=0, cdb_jump_choice=0, cdb_pc=0, cdb_src=0; alu_ready=lsb_ready=1 after reset.
REQ-032 Reset mid-operation SHALL discard all queued results; no broadcast in the first cycle after release.

Structure
REQ-033 ID_W, ROB size and source encoding (SRC_ALU=0, SRC_LSB=1) SHALL live in the shared constants package with the other ROB defines.
REQ-034 The queue SHALL be a sub-module result_fifo (parameters DEPTH, payload width) instantiated once per source; arbitration and output registers in cdb_arbiter.

Verification
REQ-035 Reset, push ALU id=3 res=0x11 at edge 1 -> cdb_valid with id=3 res=0x11 src=0 after edge 2 only.
REQ-036 ALU id=1 and LSB id=2 pushed same edge after reset -> ALU id=1 broadcast first, LSB id=2 next cycle.
REQ-037 ALU pushes 1,2 and LSB pushes 4,5 continuously -> order 1,4,2,5, alu_ready low while ALU count=2.
REQ-038 Queues holding 3 entries, flush high one edge with LSB push id=7 -> no broadcast after, id=7 never appears, both ready=1.
REQ-039 rdy low for 3 cycles with entries queued -> cdb outputs and readies frozen; resume yields identical sequence as without stall.
REQ-040 Async rst asserted between edges with full queues -> cdb_valid=0 immediately, no queued result broadcast after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared ROB constants and the common data bus source encoding.
//   ROB_ID_W  : width of a ROB entry id
//   ROB_SIZE  : number of ROB entries addressed by ROB_ID_W
//   DATA_W    : width of a result value / branch target
//   src_e     : which execution unit owns a CDB broadcast
// ----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int ROB_ID_W = 5;
    localparam int ROB_SIZE = 1 << ROB_ID_W;
    localparam int DATA_W   = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

endpackage

// File: rtl/result_fifo.sv
// ----------------------------------------------------------------------------
// result_fifo
// Small circular FIFO holding completed results for one execution unit.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : synchronous empty (flush); wins over push/pop
//   push, din    : write one entry (caller guarantees not full)
//   pop          : drop the head entry (caller guarantees not empty)
//   dout         : head entry, valid while !empty
//   ready        : not full, from registered count only
//   empty        : no entries held
// ----------------------------------------------------------------------------
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 70
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             ready,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an empty count makes stale contents
    // unreachable, so clearing it would only cost reset routing.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign ready = (count != CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter
// Queues ALU and LSB results and broadcasts one per cycle on the common data
// bus, round-robin between the two sources when both have work.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   rdy                             : global enable, low freezes everything
//   flush                           : mispredict flush, empties both queues
//   alu_valid/res/rob_id/jump_choice/pc, alu_ready : ALU result offer
//   lsb_valid/res/rob_id, lsb_ready : LSB result offer
//   cdb_valid/rob_id/res/jump_choice/pc/src        : registered broadcast
// ----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int ID_W  = ROB_ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,

    input  logic              alu_valid,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [ID_W-1:0]   alu_rob_id,
    input  logic              alu_jump_choice,
    input  logic [DATA_W-1:0] alu_pc,
    output logic              alu_ready,

    input  logic              lsb_valid,
    input  logic [DATA_W-1:0] lsb_res,
    input  logic [ID_W-1:0]   lsb_rob_id,
    output logic              lsb_ready,

    output logic              cdb_valid,
    output logic [ID_W-1:0]   cdb_rob_id,
    output logic [DATA_W-1:0] cdb_res,
    output logic              cdb_jump_choice,
    output logic [DATA_W-1:0] cdb_pc,
    output logic              cdb_src
);

    // Payload layout: {rob_id, res, jump_choice, pc}
    localparam int PAY_W = ID_W + DATA_W + 1 + DATA_W;

    logic             active;
    logic             alu_push, lsb_push;
    logic             alu_pop, lsb_pop;
    logic             alu_empty, lsb_empty;
    logic [PAY_W-1:0] alu_din, lsb_din;
    logic [PAY_W-1:0] alu_head, lsb_head;
    logic             grant_alu, grant_lsb;
    logic [PAY_W-1:0] win_payload;
    src_e             win_src;
    src_e             last_grant;

    assign active   = rdy && !flush;
    assign alu_push = active && alu_valid && alu_ready;
    assign lsb_push = active && lsb_valid && lsb_ready;
    assign alu_pop  = active && grant_alu;
    assign lsb_pop  = active && grant_lsb;

    assign alu_din = {alu_rob_id, alu_res, alu_jump_choice, alu_pc};
    // Loads never resolve branches, so their direction and target are zero.
    assign lsb_din = {lsb_rob_id, lsb_res, 1'b0, {DATA_W{1'b0}}};

    result_fifo #(.DEPTH(DEPTH), .WIDTH(PAY_W)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (rdy && flush),
        .push  (alu_push),
        .din   (alu_din),
        .pop   (alu_pop),
        .dout  (alu_head),
        .ready (alu_ready),
        .empty (alu_empty)
    );

    result_fifo #(.DEPTH(DEPTH), .WIDTH(PAY_W)) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (rdy && flush),
        .push  (lsb_push),
        .din   (lsb_din),
        .pop   (lsb_pop),
        .dout  (lsb_head),
        .ready (lsb_ready),
        .empty (lsb_empty)
    );

    // Grant uses only the pre-edge queue state, so an entry pushed this edge
    // cannot be broadcast until the following edge.
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        grant_alu   = 1'b0;
        grant_lsb   = 1'b0;
        win_src     = SRC_ALU;
        win_payload = alu_head;
        if (!alu_empty && (lsb_empty || last_grant == SRC_LSB)) begin
            grant_alu = 1'b1;
        end else if (!lsb_empty) begin
            grant_lsb   = 1'b1;
            win_src     = SRC_LSB;
            win_payload = lsb_head;
        end
    end

    // Payload registers hold their last value when nothing is broadcast;
    // consumers qualify them with cdb_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid       <= 1'b0;
            cdb_rob_id      <= '0;
            cdb_res         <= '0;
            cdb_jump_choice <= 1'b0;
            cdb_pc          <= '0;
            cdb_src         <= 1'b0;
            last_grant      <= SRC_LSB;
        end else if (rdy) begin
            if (flush) begin
                cdb_valid  <= 1'b0;
                last_grant <= SRC_LSB;
            end else if (grant_alu || grant_lsb) begin
                cdb_valid <= 1'b1;
                {cdb_rob_id, cdb_res, cdb_jump_choice, cdb_pc} <= win_payload;
                cdb_src    <= win_src;
                last_grant <= win_src;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

    // Offering a result to a full queue is a producer bug: the result is lost.
    a_alu_no_overflow : assert property (@(posedge clk) disable iff (rst)
        (rdy && !flush && alu_valid) |-> alu_ready);
    a_lsb_no_overflow : assert property (@(posedge clk) disable iff (rst)
        (rdy && !flush && lsb_valid) |-> lsb_ready);

endmodule

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed stimulus for cdb_arbiter. Stimulus pushes hand-ordered expected
// broadcasts into a scoreboard queue; a monitor pops and compares every fresh
// broadcast. Direct checks cover reset values, readies, latency and freezes.
// ----------------------------------------------------------------------------
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        alu_valid;
    logic [31:0] alu_res;
    logic [4:0]  alu_rob_id;
    logic        alu_jump_choice;
    logic [31:0] alu_pc;
    logic        alu_ready;
    logic        lsb_valid;
    logic [31:0] lsb_res;
    logic [4:0]  lsb_rob_id;
    logic        lsb_ready;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_res;
    logic        cdb_jump_choice;
    logic [31:0] cdb_pc;
    logic        cdb_src;

    int checks = 0;
    int errors = 0;
    logic [127:0] sb[$];

    always #5 clk = ~clk;

    cdb_arbiter #(.DEPTH(2), .ID_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .flush           (flush),
        .alu_valid       (alu_valid),
        .alu_res         (alu_res),
        .alu_rob_id      (alu_rob_id),
        .alu_jump_choice (alu_jump_choice),
        .alu_pc          (alu_pc),
        .alu_ready       (alu_ready),
        .lsb_valid       (lsb_valid),
        .lsb_res         (lsb_res),
        .lsb_rob_id      (lsb_rob_id),
        .lsb_ready       (lsb_ready),
        .cdb_valid       (cdb_valid),
        .cdb_rob_id      (cdb_rob_id),
        .cdb_res         (cdb_res),
        .cdb_jump_choice (cdb_jump_choice),
        .cdb_pc          (cdb_pc),
        .cdb_src         (cdb_src)
    );

    function automatic logic [127:0] pack(input logic src, input logic [4:0] id,
                                          input logic [31:0] res, input logic jc,
                                          input logic [31:0] pc);
        return {57'b0, src, id, res, jc, pc};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_alu(input logic [4:0] id, input logic [31:0] res,
                           input logic jc, input logic [31:0] pc);
        sb.push_back(pack(1'b0, id, res, jc, pc));
    endtask

    task automatic exp_lsb(input logic [4:0] id, input logic [31:0] res);
        sb.push_back(pack(1'b1, id, res, 1'b0, 32'h0));
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] id, input logic [31:0] res,
                             input logic jc, input logic [31:0] pc);
        alu_valid = v; alu_rob_id = id; alu_res = res; alu_jump_choice = jc; alu_pc = pc;
    endtask

    task automatic drive_lsb(input logic v, input logic [4:0] id, input logic [31:0] res);
        lsb_valid = v; lsb_rob_id = id; lsb_res = res;
    endtask

    task automatic idle();
        drive_alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        drive_lsb(1'b0, 5'd0, 32'h0);
        flush = 1'b0;
        rdy   = 1'b1;
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid",     cdb_valid,       0);
        check("rst_rob_id",    cdb_rob_id,      0);
        check("rst_res",       cdb_res,         0);
        check("rst_jump",      cdb_jump_choice, 0);
        check("rst_pc",        cdb_pc,          0);
        check("rst_src",       cdb_src,         0);
        check("rst_alu_ready", alu_ready,       1);
        check("rst_lsb_ready", lsb_ready,       1);
    endtask

    task automatic drain(input string name);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: compare only broadcasts freshly loaded at an enabled edge, so a
    // frozen cdb_valid during rdy low is not counted twice.
    initial begin : monitor
        logic         edge_ok;
        logic [127:0] act;
        forever begin
            @(posedge clk);
            edge_ok = rdy && !rst;
            @(negedge clk);
            if (edge_ok && cdb_valid) begin
                act = pack(cdb_src, cdb_rob_id, cdb_res, cdb_jump_choice, cdb_pc);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bcast: got %0h expected no broadcast", act);
                end else begin
                    check("bcast", act, sb.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();

        // Single ALU result: no bypass, appears after the second edge.
        do_reset();
        drive_alu(1'b1, 5'd3, 32'h11, 1'b1, 32'h100);
        exp_alu(5'd3, 32'h11, 1'b1, 32'h100);
        tick();
        idle();
        @(negedge clk); check("t1_no_bypass", cdb_valid, 0);
        tick();
        @(negedge clk); check("t1_latency", cdb_valid, 1);
        tick();
        @(negedge clk); check("t1_idle", cdb_valid, 0);
        drain("t1_drain");

        // Simultaneous first push: ALU wins the first tie.
        do_reset();
        drive_alu(1'b1, 5'd1, 32'hA1, 1'b0, 32'h0);
        drive_lsb(1'b1, 5'd2, 32'hB2);
        exp_alu(5'd1, 32'hA1, 1'b0, 32'h0);
        exp_lsb(5'd2, 32'hB2);
        tick();
        idle();
        @(negedge clk); check("t2_no_bypass", cdb_valid, 0);
        tick();
        @(negedge clk); check("t2_alu_first", cdb_src, 0);
        tick();
        @(negedge clk); check("t2_lsb_next", cdb_src, 1);
        repeat (2) tick();
        drain("t2_drain");

        // Continuous offers: round-robin order 1,4,2,5,3 and back-pressure.
        do_reset();
        exp_alu(5'd1, 32'h1001, 1'b1, 32'h2001);
        exp_lsb(5'd4, 32'h4004);
        exp_alu(5'd2, 32'h1002, 1'b0, 32'h2002);
        exp_lsb(5'd5, 32'h4005);
        exp_alu(5'd3, 32'h1003, 1'b1, 32'h2003);
        drive_alu(1'b1, 5'd1, 32'h1001, 1'b1, 32'h2001);
        drive_lsb(1'b1, 5'd4, 32'h4004);
        tick();
        drive_alu(1'b1, 5'd2, 32'h1002, 1'b0, 32'h2002);
        drive_lsb(1'b1, 5'd5, 32'h4005);
        tick();
        @(negedge clk);
        check("t3_lsb_full",  lsb_ready, 0);
        check("t3_alu_room",  alu_ready, 1);
        check("t3_valid_e2",  cdb_valid, 1);
        drive_alu(1'b1, 5'd3, 32'h1003, 1'b1, 32'h2003);
        drive_lsb(1'b0, 5'd0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        check("t3_alu_full",  alu_ready, 0);
        check("t3_lsb_room",  lsb_ready, 1);
        check("t3_valid_e3",  cdb_valid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk); check("t3_sustained", cdb_valid, 1);
        end
        tick();
        @(negedge clk); check("t3_idle", cdb_valid, 0);
        drain("t3_drain");

        // Flush with three entries queued and a same-edge LSB push of id 7.
        do_reset();
        exp_alu(5'd10, 32'hA10, 1'b0, 32'h0);
        drive_alu(1'b1, 5'd10, 32'hA10, 1'b0, 32'h0);
        drive_lsb(1'b1, 5'd20, 32'hB20);
        tick();
        drive_alu(1'b1, 5'd11, 32'hA11, 1'b1, 32'h44);
        drive_lsb(1'b1, 5'd21, 32'hB21);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        drive_lsb(1'b1, 5'd7, 32'h777);
        flush = 1'b1;
        tick();
        idle();
        @(negedge clk);
        check("t4_flush_valid", cdb_valid, 0);
        check("t4_alu_ready",   alu_ready, 1);
        check("t4_lsb_ready",   lsb_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk); check("t4_quiet", cdb_valid, 0);
        end
        drain("t4_drain");

        // rdy low for three edges with junk inputs and flush: everything frozen.
        do_reset();
        exp_alu(5'd21, 32'hC21, 1'b1, 32'h21);
        exp_lsb(5'd22, 32'hD22);
        exp_alu(5'd23, 32'hC23, 1'b0, 32'h23);
        exp_lsb(5'd24, 32'hD24);
        drive_alu(1'b1, 5'd21, 32'hC21, 1'b1, 32'h21);
        drive_lsb(1'b1, 5'd22, 32'hD22);
        tick();
        drive_alu(1'b1, 5'd23, 32'hC23, 1'b0, 32'h23);
        drive_lsb(1'b1, 5'd24, 32'hD24);
        tick();
        rdy   = 1'b0;
        flush = 1'b1;
        drive_alu(1'b1, 5'd30, 32'hDEAD, 1'b1, 32'hBEEF);
        drive_lsb(1'b1, 5'd31, 32'hF00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t5_hold_valid", cdb_valid,  1);
            check("t5_hold_id",    cdb_rob_id, 21);
            check("t5_hold_alu_r", alu_ready,  1);
            check("t5_hold_lsb_r", lsb_ready,  0);
        end
        idle();
        repeat (5) tick();
        drain("t5_drain");

        // Asynchronous reset between edges with results still queued.
        do_reset();
        exp_alu(5'd31, 32'hE31, 1'b0, 32'h31);
        drive_alu(1'b1, 5'd31, 32'hE31, 1'b0, 32'h31);
        drive_lsb(1'b1, 5'd12, 32'hE32);
        tick();
        drive_alu(1'b1, 5'd13, 32'hE33, 1'b1, 32'h33);
        drive_lsb(1'b1, 5'd14, 32'hE34);
        tick();
        idle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", cdb_valid,  0);
        check("t6_async_id",    cdb_rob_id, 0);
        check("t6_async_alu_r", alu_ready,  1);
        check("t6_async_lsb_r", lsb_ready,  1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("t6_no_stale", cdb_valid, 0);
            tick();
        end
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
